// File: rtl/ram_bank.sv
// Single-port request/acknowledge RAM slave with byte-enable writes, registered
// read data, out-of-range error responses and an optional zero-fill sweep after reset.
module ram_bank #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [31:0]         mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                mem_err,
  output logic                init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(BYTES);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_RST  = INIT_ZERO ? ST_INIT : ST_IDLE;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [1:0]        state_r;
  logic [AW-1:0]     cnt_r;
  logic              held_r;
  logic [DATA_W-1:0] mem_rdata_r;
  logic              mem_ack_r;
  logic              mem_err_r;
  logic              init_done_r;

  logic [31:0]       off_s;
  logic              in_range_s;
  logic [AW-1:0]     idx_s;
  logic              accept_s;
  logic              wr_en_s;
  logic [AW-1:0]     wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [BYTES-1:0]  wr_be_s;

  // Address decode and request acceptance
  always_comb begin
    off_s      = mem_addr - BASE_ADDR;
    idx_s      = off_s[BW +: AW];
    in_range_s = 1'b0;
    accept_s   = 1'b0;
    if ((mem_addr >= BASE_ADDR) && ({1'b0, off_s} < SPAN)) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
    // held_r blocks re-acceptance of a request the master never dropped
    if ((state_r == ST_IDLE) && mem_req && !held_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Single write port shared by the zero-fill sweep and bus writes
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = {AW{1'b0}};
    wr_data_s = {DATA_W{1'b0}};
    wr_be_s   = {BYTES{1'b0}};
    if (!rst) begin
      wr_en_s = 1'b0;
    end else if (state_r == ST_INIT) begin
      wr_en_s  = 1'b1;
      wr_idx_s = cnt_r;
      wr_be_s  = {BYTES{1'b1}};
    end else if (accept_s && mem_we && in_range_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = idx_s;
      wr_data_s = mem_wdata;
      wr_be_s   = mem_be;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array; contents are defined by the sweep, not by reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be_s[i]) begin
          mem_r[wr_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

  // Control FSM and registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_RST;
      cnt_r       <= {AW{1'b0}};
      held_r      <= 1'b0;
      mem_rdata_r <= {DATA_W{1'b0}};
      mem_ack_r   <= 1'b0;
      mem_err_r   <= 1'b0;
      init_done_r <= !INIT_ZERO;
    end else begin
      if (accept_s) begin
        held_r <= 1'b1;
      end else if (!mem_req) begin
        held_r <= 1'b0;
      end
      case (state_r)
        ST_INIT: begin
          mem_ack_r <= 1'b0;
          mem_err_r <= 1'b0;
          if (cnt_r == AW'(DEPTH - 1)) begin
            cnt_r       <= {AW{1'b0}};
            state_r     <= ST_IDLE;
            init_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + AW'(1);
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_RESP;
            mem_ack_r <= 1'b1;
            mem_err_r <= !in_range_s;
            if (!mem_we) begin
              mem_rdata_r <= in_range_s ? mem_r[idx_s] : {DATA_W{1'b0}};
            end
          end else begin
            mem_ack_r <= 1'b0;
            mem_err_r <= 1'b0;
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          mem_ack_r <= 1'b0;
          mem_err_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_ack_r <= 1'b0;
          mem_err_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rdata = mem_rdata_r;
  assign mem_ack   = mem_ack_r;
  assign mem_err   = mem_err_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_ram_bank.sv
// Directed self-checking bench for ram_bank: DATA_W=32, DEPTH=16, BASE_ADDR=0x1000, INIT_ZERO=1.
module tb_ram_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic        init_done;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  ram_bank #(
    .DATA_W(32), .DEPTH(16), .BASE_ADDR(32'h0000_1000), .INIT_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One complete transaction; returns the response sampled just after the accept edge
  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output logic a, output logic e,
                        output logic [31:0] rd, output int c);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_be = be; mem_addr = addr; mem_wdata = wd;
    @(posedge clk); #1;
    a = mem_ack; e = mem_err; rd = mem_rdata; c = cyc;
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  task automatic test_reset();
    logic saw_ack;
    mem_req = 1'b0; mem_we = 1'b0; mem_be = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    rst = 1'b0;
    #12;
    total++; if (mem_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", mem_ack); else passed++;
    total++; if (mem_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", mem_err); else passed++;
    total++; if (mem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", mem_rdata); else passed++;
    total++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b expected 0", init_done); else passed++;
    @(negedge clk);
    rst = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_103C;
    saw_ack = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (mem_ack === 1'b1) saw_ack = 1'b1;
      if (i == 15) begin
        total++; if (init_done !== 1'b0) $display("FAIL init_done_early: got %b expected 0", init_done); else passed++;
      end
      if (i == 16) begin
        total++; if (init_done !== 1'b1) $display("FAIL init_done_rise: got %b expected 1", init_done); else passed++;
      end
    end
    total++; if (saw_ack !== 1'b0) $display("FAIL ack_during_init: got %b expected 0", saw_ack); else passed++;
    @(posedge clk); #1;
    total++; if (mem_ack !== 1'b1) $display("FAIL post_init_ack: got %b expected 1", mem_ack); else passed++;
    total++; if (mem_rdata !== 32'h0) $display("FAIL post_init_rdata: got %h expected 0", mem_rdata); else passed++;
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  task automatic test_full_word();
    logic a, e; logic [31:0] rd; int c;
    access(1'b1, 4'hF, 32'h0000_1008, 32'hDEAD_BEEF, a, e, rd, c);
    total++; if ({a, e} !== 2'b10) $display("FAIL fw_write_resp: got ack/err %b%b expected 10", a, e); else passed++;
    access(1'b0, 4'h0, 32'h0000_1008, 32'h0, a, e, rd, c);
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL fw_read: got %h expected deadbeef", rd); else passed++;
  endtask

  task automatic test_byte_en();
    logic a, e; logic [31:0] rd; int c;
    access(1'b1, 4'b0101, 32'h0000_1008, 32'h1122_3344, a, e, rd, c);
    access(1'b0, 4'h0, 32'h0000_1008, 32'h0, a, e, rd, c);
    total++; if (rd !== 32'hDE22_BE44) $display("FAIL be_merge: got %h expected de22be44", rd); else passed++;
    access(1'b1, 4'h0, 32'h0000_1008, 32'hFFFF_FFFF, a, e, rd, c);
    total++; if (a !== 1'b1) $display("FAIL be_zero_ack: got %b expected 1", a); else passed++;
    total++; if (rd !== 32'hDE22_BE44) $display("FAIL rdata_hold_on_write: got %h expected de22be44", rd); else passed++;
    access(1'b0, 4'h0, 32'h0000_100A, 32'h0, a, e, rd, c);
    total++; if (rd !== 32'hDE22_BE44) $display("FAIL be_zero_unchanged: got %h expected de22be44", rd); else passed++;
  endtask

  task automatic test_range();
    logic a, e; logic [31:0] rd; int c;
    access(1'b1, 4'hF, 32'h0000_1000, 32'hA5A5_A5A5, a, e, rd, c);
    access(1'b1, 4'hF, 32'h0000_103C, 32'h5A5A_5A5A, a, e, rd, c);
    access(1'b0, 4'h0, 32'h0000_103C, 32'h0, a, e, rd, c);
    total++; if ({a, e} !== 2'b10) $display("FAIL top_word_resp: got ack/err %b%b expected 10", a, e); else passed++;
    total++; if (rd !== 32'h5A5A_5A5A) $display("FAIL top_word_data: got %h expected 5a5a5a5a", rd); else passed++;
    access(1'b0, 4'h0, 32'h0000_1040, 32'h0, a, e, rd, c);
    total++; if ({a, e} !== 2'b11) $display("FAIL above_range_resp: got ack/err %b%b expected 11", a, e); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL above_range_rdata: got %h expected 0", rd); else passed++;
    access(1'b0, 4'h0, 32'h0000_0FFC, 32'h0, a, e, rd, c);
    total++; if ({a, e} !== 2'b11) $display("FAIL below_range_resp: got ack/err %b%b expected 11", a, e); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL below_range_rdata: got %h expected 0", rd); else passed++;
    access(1'b1, 4'hF, 32'h0000_1040, 32'hFFFF_FFFF, a, e, rd, c);
    total++; if ({a, e} !== 2'b11) $display("FAIL oor_write_resp: got ack/err %b%b expected 11", a, e); else passed++;
    access(1'b0, 4'h0, 32'h0000_1003, 32'h0, a, e, rd, c);
    total++; if (rd !== 32'hA5A5_A5A5) $display("FAIL oor_write_word0: got %h expected a5a5a5a5", rd); else passed++;
    access(1'b0, 4'h0, 32'h0000_103C, 32'h0, a, e, rd, c);
    total++; if (rd !== 32'h5A5A_5A5A) $display("FAIL oor_write_word15: got %h expected 5a5a5a5a", rd); else passed++;
  endtask

  task automatic test_handshake();
    int acks;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'h0; mem_addr = 32'h0000_1000;
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ack === 1'b1) acks++;
    end
    total++; if (acks !== 1) $display("FAIL held_req_acks: got %0d expected 1", acks); else passed++;
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic a1, e1, a2, e2; logic [31:0] rd1, rd2; int c1, c2;
    access(1'b1, 4'hF, 32'h0000_1010, 32'hCAFE_F00D, a1, e1, rd1, c1);
    access(1'b0, 4'h0, 32'h0000_1010, 32'h0, a2, e2, rd2, c2);
    total++; if ({a1, a2} !== 2'b11) $display("FAIL b2b_acks: got %b%b expected 11", a1, a2); else passed++;
    total++; if (c2 - c1 !== 2) $display("FAIL b2b_spacing: got %0d expected 2", c2 - c1); else passed++;
    total++; if (rd2 !== 32'hCAFE_F00D) $display("FAIL b2b_raw: got %h expected cafef00d", rd2); else passed++;
  endtask

  task automatic test_reset_mid();
    logic a, e; logic [31:0] rd; int c;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'h0; mem_addr = 32'h0000_1010;
    @(posedge clk); #1;
    total++; if (mem_rdata !== 32'hCAFE_F00D) $display("FAIL pre_reset_rdata: got %h expected cafef00d", mem_rdata); else passed++;
    #2; rst = 1'b0; #1;
    total++; if (mem_ack !== 1'b0) $display("FAIL mid_reset_ack: got %b expected 0", mem_ack); else passed++;
    total++; if (mem_rdata !== 32'h0) $display("FAIL mid_reset_rdata: got %h expected 0", mem_rdata); else passed++;
    total++; if (init_done !== 1'b0) $display("FAIL mid_reset_init_done: got %b expected 0", init_done); else passed++;
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    total++; if (init_done !== 1'b1) $display("FAIL resweep_done: got %b expected 1", init_done); else passed++;
    access(1'b0, 4'h0, 32'h0000_1010, 32'h0, a, e, rd, c);
    total++; if ({a, rd} !== {1'b1, 32'h0}) $display("FAIL resweep_clear: got ack %b data %h expected ack 1 data 0", a, rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_en();
    test_range();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
